// File: rtl/menu_flow_ctrl.sv
// menu_flow_ctrl: game-flow sequencer for the difficulty menu.
//
// Conditions the four raw push buttons (two-flop synchronizer, debounce,
// rising-edge press pulse). It then runs the MENU -> PLAYING -> RESULT -> MENU
// flow:
//   - In MENU, a three-entry cursor moves with up/down, and select latches
//     the difficulty.
//   - PLAYING ends on back (straight to MENU), game_over or level_done.
//   - RESULT is held for RESULT_CYCLES, or skipped with select.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   btn_up/down    raw cursor buttons
//   btn_select     raw confirm / skip button
//   btn_back       raw abort-game button
//   game_over      synchronous pulse, player hit a wall
//   level_done     synchronous pulse, player reached the goal
//   sel_idx        cursor position 0..2
//   cursor_enable  high in MENU
//   game_enable    high in PLAYING
//   difficulty     difficulty latched on select, 0..2
//   game_start     one-cycle pulse on MENU -> PLAYING
//   result_on      high in RESULT
//   result_win     1 = level_done, 0 = game_over (valid while result_on)
//   state          MENU=00, PLAYING=01, RESULT=10
module menu_flow_ctrl #(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int RESULT_CYCLES = 200_000_000,
  parameter int CNT_W         = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic       game_over,
  input  logic       level_done,
  output logic [1:0] sel_idx,
  output logic       cursor_enable,
  output logic       game_enable,
  output logic [1:0] difficulty,
  output logic       game_start,
  output logic       result_on,
  output logic       result_win,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    MENU    = 2'b00,
    PLAYING = 2'b01,
    RESULT  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam int NB  = 4;
  localparam int UP  = 0;
  localparam int DN  = 1;
  localparam int SEL = 2;
  localparam int BK  = 3;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RESULT_CYCLES - 1);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    deb;
  logic [NB-1:0]    deb_d;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] deb_cnt [NB];

  state_t           st;
  logic [CNT_W-1:0] res_cnt;

  assign raw = {btn_back, btn_select, btn_down, btn_up};

  // Button conditioning. The debounce counter only runs while the
  // synchronized input disagrees with the debounced level. Any agreeing
  // sample restarts it, so only an unbroken run of DEB_CYCLES differing
  // samples flips the level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < NB; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Registered rising edge of the debounced level; releases give nothing.
      press <= deb & ~deb_d;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          deb[i]     <= ~deb[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Flow FSM. game_start defaults low so that it is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= MENU;
      sel_idx    <= 2'd0;
      difficulty <= 2'd0;
      game_start <= 1'b0;
      result_win <= 1'b0;
      res_cnt    <= '0;
    end else begin
      game_start <= 1'b0;
      case (st)
        MENU: begin
          // Select takes the cursor as it stands and overrides any
          // up/down pulse in the same cycle.
          if (press[SEL]) begin
            difficulty <= sel_idx;
            game_start <= 1'b1;
            st         <= PLAYING;
          end else if (press[UP] && !press[DN]) begin
            sel_idx <= (sel_idx == 2'd0) ? 2'd2 : sel_idx - 2'd1;
          end else if (press[DN] && !press[UP]) begin
            sel_idx <= (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
          end
        end
        PLAYING: begin
          // Back beats game events; game_over beats level_done.
          if (press[BK]) begin
            st <= MENU;
          end else if (game_over) begin
            result_win <= 1'b0;
            res_cnt    <= '0;
            st         <= RESULT;
          end else if (level_done) begin
            result_win <= 1'b1;
            res_cnt    <= '0;
            st         <= RESULT;
          end
        end
        RESULT: begin
          if (press[SEL] || res_cnt == RES_LAST) begin
            res_cnt <= '0;
            st      <= MENU;
          end else begin
            res_cnt <= res_cnt + 1'b1;
          end
        end
        default: begin
          st <= MENU;
        end
      endcase
    end
  end

  assign state         = st;
  assign cursor_enable = (st == MENU);
  assign game_enable   = (st == PLAYING);
  assign result_on     = (st == RESULT);

endmodule

// File: tb/tb_menu_flow_ctrl.sv
module tb_menu_flow_ctrl;

  localparam int DEB = 4;
  localparam int RC  = 16;
  localparam int HL  = DEB + 2;
  localparam int UP  = 0;
  localparam int DN  = 1;
  localparam int SEL = 2;
  localparam int BK  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btns = 4'b0000;
  logic       game_over = 1'b0;
  logic       level_done = 1'b0;
  logic [1:0] sel_idx;
  logic [1:0] difficulty;
  logic [1:0] state;
  logic       cursor_enable;
  logic       game_enable;
  logic       game_start;
  logic       result_on;
  logic       result_win;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  menu_flow_ctrl #(
    .DEB_CYCLES(DEB),
    .RESULT_CYCLES(RC),
    .CNT_W(28)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btns[UP]),
    .btn_down(btns[DN]),
    .btn_select(btns[SEL]),
    .btn_back(btns[BK]),
    .game_over(game_over),
    .level_done(level_done),
    .sel_idx(sel_idx),
    .cursor_enable(cursor_enable),
    .game_enable(game_enable),
    .difficulty(difficulty),
    .game_start(game_start),
    .result_on(result_on),
    .result_win(result_win),
    .state(state)
  );

  // Behavioural model.
  // A button's debounced level flips once the last DEB samples seen through
  // the two-stage synchronizer all disagree with it. The FSM sees a press
  // two edges after the level rises. RESULT is left once RC cycles have
  // elapsed since entry.
  int m_state = 0;
  int m_sel   = 0;
  int m_diff  = 0;
  int m_t0    = 0;
  int cyc     = 0;
  bit m_start = 1'b0;
  bit m_win   = 1'b0;
  bit hist  [4][HL];
  bit m_deb [4];
  bit m_d1  [4];
  bit m_d2  [4];
  bit use_p [4];
  bit all_diff;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0;
      m_sel   = 0;
      m_diff  = 0;
      m_start = 1'b0;
      m_win   = 1'b0;
      for (int b = 0; b < 4; b++) begin
        m_deb[b] = 1'b0;
        m_d1[b]  = 1'b0;
        m_d2[b]  = 1'b0;
        for (int k = 0; k < HL; k++) hist[b][k] = 1'b0;
      end
    end else begin
      cyc++;
      for (int b = 0; b < 4; b++) begin
        use_p[b] = m_d2[b];
        for (int k = HL - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = btns[b];
        all_diff = 1'b1;
        for (int k = 2; k < HL; k++) if (hist[b][k] == m_deb[b]) all_diff = 1'b0;
        m_d2[b] = m_d1[b];
        m_d1[b] = all_diff && !m_deb[b];
        if (all_diff) m_deb[b] = !m_deb[b];
      end
      m_start = 1'b0;
      case (m_state)
        0: begin
          if (use_p[SEL]) begin
            m_diff  = m_sel;
            m_start = 1'b1;
            m_state = 1;
          end else if (use_p[UP] && !use_p[DN]) begin
            m_sel = (m_sel + 2) % 3;
          end else if (use_p[DN] && !use_p[UP]) begin
            m_sel = (m_sel + 1) % 3;
          end
        end
        1: begin
          if (use_p[BK]) m_state = 0;
          else if (game_over)  begin m_win = 1'b0; m_state = 2; m_t0 = cyc; end
          else if (level_done) begin m_win = 1'b1; m_state = 2; m_t0 = cyc; end
        end
        default: begin
          if (use_p[SEL] || (cyc - m_t0) == RC) m_state = 0;
        end
      endcase
    end
  end

  function automatic logic [10:0] exp_vec();
    return {2'(m_state), 2'(m_sel), 2'(m_diff), m_start, m_win,
            (m_state == 0), (m_state == 1), (m_state == 2)};
  endfunction

  always @(negedge clk) begin
    checks++;
    if ({state, sel_idx, difficulty, game_start, result_win,
         cursor_enable, game_enable, result_on} === exp_vec()) begin
      passed++;
    end else begin
      $display("FAIL cycle_compare t=%0t dut=%b model=%b", $time,
               {state, sel_idx, difficulty, game_start, result_win,
                cursor_enable, game_enable, result_on}, exp_vec());
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    btns = m;
    step(hold);
    btns = 4'b0000;
    step(DEB + 5);
  endtask

  initial begin
    #2 reset = 1'b0;
    step(3);
    chk("rst_state", state, 0);
    chk("rst_sel", sel_idx, 0);
    chk("rst_diff", difficulty, 0);
    chk("rst_cursor_en", cursor_enable, 1);
    chk("rst_game_en", game_enable, 0);
    chk("rst_result_on", result_on, 0);
    chk("rst_game_start", game_start, 0);
    reset = 1'b1;
    step(2);

    // 1: latency of DEB+3 edges to the pulse, so the cursor moves one edge later.
    for (int r = 1; r <= 2; r++) begin
      btns[DN] = 1'b1;
      step(DEB + 3);
      chk("t1_before_pulse", sel_idx, r - 1);
      step(1);
      chk("t1_after_pulse", sel_idx, r);
      step(1);
      btns = 4'b0000;
      step(DEB + 5);
    end
    btns[DN] = 1'b1;
    step(3);
    btns = 4'b0000;
    step(DEB + 5);
    chk("t1_glitch_ignored", sel_idx, 2);

    // 2: wrap-around in both directions, and up+down cancelling.
    press(4'b0010, DEB + 5);
    chk("t2_down_wrap", sel_idx, 0);
    press(4'b0001, DEB + 5);
    chk("t2_up_wrap", sel_idx, 2);
    press(4'b0011, DEB + 5);
    chk("t2_up_down_same", sel_idx, 2);
    press(4'b0010, DEB + 5);
    press(4'b0010, DEB + 5);
    chk("t2_sel_1", sel_idx, 1);

    // 3: select starts the game.
    btns[SEL] = 1'b1;
    step(DEB + 3);
    chk("t3_start_early", game_start, 0);
    step(1);
    chk("t3_start_pulse", game_start, 1);
    chk("t3_state", state, 1);
    chk("t3_diff", difficulty, 1);
    chk("t3_cursor_en", cursor_enable, 0);
    chk("t3_game_en", game_enable, 1);
    step(1);
    chk("t3_start_one_cycle", game_start, 0);
    btns = 4'b0000;
    step(DEB + 5);
    press(4'b0001, DEB + 5);
    press(4'b0010, DEB + 5);
    chk("t3_sel_held", sel_idx, 1);
    chk("t3_still_playing", state, 1);

    // 4: game_over wins over level_done, then RESULT times out.
    game_over  = 1'b1;
    level_done = 1'b1;
    step(1);
    game_over  = 1'b0;
    level_done = 1'b0;
    chk("t4_state", state, 2);
    chk("t4_win", result_win, 0);
    chk("t4_result_on", result_on, 1);
    step(RC - 1);
    chk("t4_still_result", state, 2);
    step(1);
    chk("t4_timeout_menu", state, 0);
    chk("t4_sel_kept", sel_idx, 1);
    chk("t4_diff_kept", difficulty, 1);

    // 5: a win, skipped with select; then abort a game with back.
    press(4'b0100, DEB + 5);
    chk("t5_playing", state, 1);
    level_done = 1'b1;
    step(1);
    level_done = 1'b0;
    chk("t5_win", result_win, 1);
    chk("t5_result", state, 2);
    btns[SEL] = 1'b1;
    step(DEB + 3);
    chk("t5_skip_early", state, 2);
    step(1);
    chk("t5_skip_menu", state, 0);
    step(1);
    btns = 4'b0000;
    step(DEB + 5);
    press(4'b0100, DEB + 5);
    chk("t5_playing_again", state, 1);
    btns[BK] = 1'b1;
    for (int i = 0; i < DEB + 5; i++) begin
      step(1);
      chk("t5_no_result_on_back", result_on, 0);
    end
    btns = 4'b0000;
    chk("t5_back_menu", state, 0);
    step(DEB + 5);

    // 6: asynchronous reset while PLAYING.
    press(4'b0100, DEB + 5);
    chk("t6_playing", state, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6_async_state", state, 0);
    chk("t6_async_sel", sel_idx, 0);
    chk("t6_async_diff", difficulty, 0);
    chk("t6_async_game_en", game_enable, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t6_no_start", game_start, 0);
    end
    chk("t6_menu", state, 0);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) btns[b] = ~btns[b];
      end
      game_over  = ($urandom_range(0, 19) == 0);
      level_done = ($urandom_range(0, 19) == 0);
      step(1);
    end
    btns       = 4'b0000;
    game_over  = 1'b0;
    level_done = 1'b0;
    step(DEB + 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
